// File: rtl/mcd_pkg.sv
// Shared types and constants for the multi-channel clock/tick divider.
package mcd_pkg;

  typedef enum logic [1:0] {
    MCD_TOGGLE = 2'd0,
    MCD_PULSE  = 2'd1,
    MCD_PWM    = 2'd2,
    MCD_RSVD   = 2'd3
  } mcd_mode_t;

  localparam int unsigned MCD_DEF_LIMIT = 50_000_000;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int mcd_ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mcd_channel.sv
// One divider channel: counter, active/shadow limit+mode, pending update, output shaping.
// MCD_DUTY_EN builds the PWM high-time registers; otherwise modes 2/3 run as toggle.
module mcd_channel
  import mcd_pkg::*;
#(
  parameter int          CW        = 27,
  parameter int unsigned DEF_LIMIT = MCD_DEF_LIMIT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          sync,
  input  logic          wr,
  input  mcd_mode_t     wr_mode,
  input  logic [CW-1:0] wr_limit,
  input  logic [CW-1:0] wr_high,
  output logic          pending,
  output logic          clk_out,
  output logic          tick
);

  localparam logic [CW-1:0] LIM_RST = CW'(DEF_LIMIT);

  logic [CW-1:0] cnt, cnt_inc, lim, sh_lim;
  mcd_mode_t     mode, sh_mode;
  logic          en_q, wrap, restart, apply;
  logic          is_pulse, is_pwm, pwm_lvl, pwm_wrap_lvl;

  assign cnt_inc  = cnt + CW'(1);
  assign wrap     = en && en_q && (cnt == lim - CW'(1));
  // First enabled cycle, disable and sync all park the counter at zero.
  assign restart  = !en || !en_q || sync;
  assign apply    = pending && (!en || sync || wrap);
  assign is_pulse = (mode == MCD_PULSE);

`ifdef MCD_DUTY_EN
  logic [CW-1:0] high, sh_high;

  assign is_pwm       = (mode == MCD_PWM);
  assign pwm_lvl      = (cnt_inc < high);
  assign pwm_wrap_lvl = (high != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high    <= LIM_RST >> 1;
      sh_high <= LIM_RST >> 1;
    end else begin
      if (wr)    sh_high <= wr_high;
      if (apply) high    <= sh_high;
    end
  end
`else
  logic unused_high;

  assign unused_high  = ^wr_high;
  assign is_pwm       = 1'b0;
  assign pwm_lvl      = 1'b0;
  assign pwm_wrap_lvl = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      lim     <= LIM_RST;
      sh_lim  <= LIM_RST;
      mode    <= MCD_TOGGLE;
      sh_mode <= MCD_TOGGLE;
      pending <= 1'b0;
      en_q    <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      en_q <= en;
      // wr needs !pending and apply needs pending, so they never collide.
      if (wr) begin
        sh_lim  <= (wr_limit == '0) ? CW'(1) : wr_limit;
        sh_mode <= wr_mode;
        pending <= 1'b1;
      end else if (apply) begin
        lim     <= sh_lim;
        mode    <= sh_mode;
        pending <= 1'b0;
      end

      if (restart) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else if (wrap) begin
        cnt  <= '0;
        tick <= 1'b1;
        if (is_pulse)    clk_out <= 1'b1;
        else if (is_pwm) clk_out <= pwm_wrap_lvl;
        else             clk_out <= ~clk_out;
      end else begin
        cnt  <= cnt_inc;
        tick <= 1'b0;
        if (is_pulse)    clk_out <= 1'b0;
        else if (is_pwm) clk_out <= pwm_lvl;
      end
    end
  end

endmodule

// File: rtl/multi_clk_div.sv
// NCH-channel programmable clock/tick divider with a valid/ready config port.
// Optional PWM mode is compiled in with MCD_DUTY_EN.
module multi_clk_div
  import mcd_pkg::*;
#(
  parameter int          NCH       = 4,
  parameter int          CW        = 27,
  parameter int unsigned DEF_LIMIT = MCD_DEF_LIMIT
) (
  input  logic                      clk,
  input  logic                      resetSW_n,
  input  logic [NCH-1:0]            en,
  input  logic                      sync,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [mcd_ch_w(NCH)-1:0]  cfg_ch,
  input  logic [1:0]                cfg_mode,
  input  logic [CW-1:0]             cfg_limit,
  input  logic [CW-1:0]             cfg_high,
  output logic [NCH-1:0]            clk_out,
  output logic [NCH-1:0]            tick
);

  localparam int CHW = mcd_ch_w(NCH);

  logic [NCH-1:0] sel, pending, wr;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NCH; i++) sel[i] = (cfg_ch == CHW'(i));
  end

  // An out-of-range channel select is never ready.
  assign cfg_ready = |(sel & ~pending);
  assign wr        = sel & {NCH{cfg_valid && cfg_ready}};

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    mcd_channel #(
      .CW        (CW),
      .DEF_LIMIT (DEF_LIMIT)
    ) u_ch (
      .clk      (clk),
      .rst_n    (resetSW_n),
      .en       (en[g]),
      .sync     (sync),
      .wr       (wr[g]),
      .wr_mode  (mcd_mode_t'(cfg_mode)),
      .wr_limit (cfg_limit),
      .wr_high  (cfg_high),
      .pending  (pending[g]),
      .clk_out  (clk_out[g]),
      .tick     (tick[g])
    );
  end

endmodule

// File: doc/multi_clk_div.md
# multi_clk_div

Parametrised multi-channel slow-clock and tick generator running from the 100 MHz base clock. Each of NCH channels divides `clk` by a runtime-programmable limit and produces either a square clock, a one-cycle tick, or (when compiled in) a PWM waveform. Limits are written through a valid/ready config port and take effect glitch-free at the channel's next period boundary. It replaces single-channel fixed-mode dividers wherever several slow enables or display/blink clocks are needed.

## Interface
- `NCH`, 4, number of independent channels (1..16)
- `CW`, 27, counter/limit width; 27 bits covers 100 M
- `DEF_LIMIT`, 50_000_000, reset limit for every channel (1 Hz square at 100 MHz)

- `clk`  in  1  base FPGA clock
- `resetSW_n`  in  1  asynchronous, active-low reset
- `en`  in  NCH  per-channel run enable
- `sync`  in  1  one-cycle pulse: restart all channels in phase
- `cfg_valid`  in  1  config write request
- `cfg_ready`  out  1  config write can be accepted for `cfg_ch`
- `cfg_ch`  in  $clog2(NCH) (min 1)  target channel
- `cfg_mode`  in  2  0 toggle, 1 pulse, 2 PWM, 3 reserved (treated as toggle)
- `cfg_limit`  in  CW  new limit L
- `cfg_high`  in  CW  PWM high time H (ignored unless `MCD_DUTY_EN` defined)
- `clk_out`  out  NCH  divided waveform per channel, registered
- `tick`  out  NCH  one-cycle strobe at each period event, registered

## Operation
- Per channel: active regs `lim`, `mode`, `high`; shadow regs plus `pending` flag; counter `cnt` (CW bits).
- L = 0 is stored as 1. Counter runs 0..L-1; wrap event when `cnt == L-1` and `en`.
- Toggle mode: on wrap `clk_out` inverts, `tick`=1. Half period = L cycles, period 2L; L=1 gives clk/2.
- Pulse mode: on wrap `clk_out`=1 and `tick`=1 for exactly one cycle, else 0. Period L; L=1 holds both high continuously.
- PWM mode (macro only): `clk_out` = (`cnt` < H); H=0 constant low, H>=L constant high; `tick` on wrap.
- `en[i]`=0: `cnt`=0, `clk_out[i]`=0, `tick[i]`=0 next cycle; pending update applied immediately.
- Config: `cfg_ready` = ~`pending[cfg_ch]` (combinational). Accept on `cfg_valid && cfg_ready` → shadow loaded, `pending`=1. Applied on the channel's next wrap (or at once if disabled): active ← shadow, `cnt`←0, `pending`←0. `clk_out` not forced on apply in toggle mode (no glitch); pulse/PWM follow new mode from the next cycle.
- `sync`: every enabled channel `cnt`←0, `clk_out`←0, `tick`←0, pending updates applied; priority over wrap in the same cycle. A config accepted in the `sync` cycle becomes pending, not applied by that `sync`.
- Reset (async, `resetSW_n`=0): `cnt`=0, `clk_out`=0, `tick`=0, `lim`=DEF_LIMIT, `mode`=toggle, `high`=DEF_LIMIT/2, `pending`=0, hence `cfg_ready`=1. Reset mid-period aborts immediately; pending writes discarded.

## Timing
- All state registered on `posedge clk`; `clk_out`/`tick` change together, one cycle after the wrap condition is sampled.
- En first sampled high at edge 0 → first toggle/tick visible after edge L.
- Config accepted at edge k, wrap at edge w ≥ k+1 → new L governs the count starting at w.
- `cfg_ready` deasserts the cycle after acceptance; reasserts the cycle after apply.

## Configuration
- `MCD_DUTY_EN` defined: mode 2 = PWM, `high` registers and comparators built, `cfg_high` used.
- Not defined: no `high` registers; `cfg_high` ignored; mode 2 and 3 behave as toggle.

## Structure
- Package `mcd_pkg`: mode typedef (`MCD_TOGGLE`=0, `MCD_PULSE`=1, `MCD_PWM`=2), default-limit constant, channel-select width function.
- Sub-module `mcd_channel`: counter, active/shadow regs, pending, output logic for one channel; top instantiates NCH copies via generate and decodes `cfg_ch`/`cfg_ready`.

## Test plan
- Reset then en[0]=1, defaults overridden with L=4 toggle → `clk_out[0]` period 8, `tick` every 4 cycles, first tick 4 cycles after en.
- Pulse mode L=3 on ch1 → `clk_out[1]`=`tick[1]` high 1 of every 3 cycles; L=0 written → behaves as L=1 (constant high).
- Write L=10 mid-period to ch2 running L=5 → `cfg_ready` low until ch2's next wrap, old period completes exactly, then 10-cycle half periods; second write while pending stalls.
- `sync` with ch0 L=4, ch1 L=6 at arbitrary phases → both `clk_out` 0 next cycle, ch0 toggles 4 later, ch1 6 later; `sync` coincident with a wrap → no toggle.
- `MCD_DUTY_EN`: PWM L=10 H=3 → 3 high/7 low; H=0 constant low; H=12 constant high; without macro same write → toggle L=10.
- Assert `resetSW_n` asynchronously mid-count with a pending write → outputs 0 immediately, `cfg_ready`=1, channel restarts with DEF_LIMIT.
